// File: rtl/led_wall_pkg.sv
// Shared types and helpers for the LED wall datapath (frame geometry, pixel layout, sequencer states).
// No logic here; latency and backpressure are properties of the modules that import it.
package led_wall_pkg;

  localparam int DEFAULT_BITS_PER_LED = 24;
  localparam int COLOR_BITS           = 8;

  // On-wire colour order is G, R, B, with the MSB sent first.
  typedef struct packed {
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] b;
  } grb_pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } seq_state_t;

  function automatic int frame_bits(input int leds_per_strand, input int bits_per_led);
    return leds_per_strand * bits_per_led;
  endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Double-buffered strand storage: back buffer written by upstream, front buffer read one bit-slice at a time.
// Writes land one cycle after the beat; swap copies back to front in one edge; the read mux is combinational.
module led_frame_buffer #(
  parameter int NUM_STRANDS = 8,
  parameter int FRAME_BITS  = 120,
  parameter int SW          = 3,
  parameter int IW          = 7
) (
  input  logic                   clk_in,
  input  logic                   ar,
  input  logic                   wr_en,
  input  logic [SW-1:0]          wr_strand,
  input  logic [FRAME_BITS-1:0]  wr_data,
  input  logic                   swap,
  input  logic [IW-1:0]          idx,
  output logic [NUM_STRANDS-1:0] slice_data
);

  logic [FRAME_BITS-1:0] front [NUM_STRANDS];
  logic [FRAME_BITS-1:0] back  [NUM_STRANDS];

  always_ff @(posedge clk_in) begin
    if (!ar) begin
      for (int s = 0; s < NUM_STRANDS; s++) begin
        front[s] <= '0;
        back[s]  <= '0;
      end
    end else begin
      // Out-of-range strand indices are dropped silently.
      if (wr_en && (int'(wr_strand) < NUM_STRANDS)) begin
        back[wr_strand] <= wr_data;
      end
      if (swap) begin
        for (int s = 0; s < NUM_STRANDS; s++) begin
          front[s] <= back[s];
        end
      end
    end
  end

  always_comb begin
    slice_data = '0;
    for (int s = 0; s < NUM_STRANDS; s++) begin
      slice_data[s] = front[s][idx];
    end
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame scheduler: streams the front frame MSB-first one slice per accepted beat, then holds a reset gap.
// Commit-to-first-slice is 2 cycles from IDLE; slices hold while slice_ready=0; wr_ready drops while a commit waits.
module led_frame_sequencer
  import led_wall_pkg::*;
#(
  parameter int NUM_STRANDS      = 8,
  parameter int LEDS_PER_STRAND  = 5,
  parameter int BITS_PER_LED     = DEFAULT_BITS_PER_LED,
  parameter int RESET_GAP_CYCLES = 1000,
  localparam int FRAME_BITS = frame_bits(LEDS_PER_STRAND, BITS_PER_LED),
  localparam int SW = (NUM_STRANDS > 1) ? $clog2(NUM_STRANDS) : 1
) (
  input  logic                   clk_in,
  input  logic                   ar,
  input  logic                   enable,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [SW-1:0]          wr_strand,
  input  logic [FRAME_BITS-1:0]  wr_data,
  input  logic                   wr_last,
  output logic [NUM_STRANDS-1:0] slice_data,
  output logic                   slice_valid,
  input  logic                   slice_ready,
  output logic                   frame_start,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int IW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int GW = (RESET_GAP_CYCLES > 1) ? $clog2(RESET_GAP_CYCLES) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(FRAME_BITS - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(RESET_GAP_CYCLES - 1);

  seq_state_t    state, state_nxt;
  logic [IW-1:0] idx;
  logic [GW-1:0] gap_cnt;
  logic          pending;
  logic          swap;
  logic          wr_fire;

  assign wr_ready    = ~pending;
  assign wr_fire     = wr_valid & wr_ready;
  assign slice_valid = (state == ST_SHIFT);
  assign busy        = (state != ST_IDLE);

  led_frame_buffer #(
    .NUM_STRANDS (NUM_STRANDS),
    .FRAME_BITS  (FRAME_BITS),
    .SW          (SW),
    .IW          (IW)
  ) u_buf (
    .clk_in     (clk_in),
    .ar         (ar),
    .wr_en      (wr_fire),
    .wr_strand  (wr_strand),
    .wr_data    (wr_data),
    .swap       (swap),
    .idx        (idx),
    .slice_data (slice_data)
  );

  // A new frame is only swapped in on the edge that enters SHIFT.
  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && pending) begin
          state_nxt = ST_SHIFT;
          swap      = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (slice_ready && (idx == '0)) begin
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          if (enable) begin
            state_nxt = ST_SHIFT;
            swap      = pending;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!ar) begin
      state       <= ST_IDLE;
      idx         <= IDX_MAX;
      gap_cnt     <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_start <= (state != ST_SHIFT) && (state_nxt == ST_SHIFT);
      frame_done  <= (state == ST_SHIFT) && (state_nxt == ST_GAP);

      if (swap) begin
        pending <= 1'b0;
      end else if (wr_fire && wr_last) begin
        pending <= 1'b1;
      end

      if ((state == ST_SHIFT) && slice_ready) begin
        if (idx == '0) begin
          idx     <= IDX_MAX;
          gap_cnt <= GAP_MAX;
        end else begin
          idx <= idx - 1'b1;
        end
      end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer with a frame-level reference model checked every cycle.
module tb_led_frame_sequencer;

  localparam int NS = 8;
  localparam int FB = 120;
  localparam int R  = 24;

  logic          clk_in = 1'b0;
  logic          ar = 1'b0;
  logic          enable = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [2:0]    wr_strand = '0;
  logic [FB-1:0] wr_data = '0;
  logic          wr_last = 1'b0;
  logic [NS-1:0] slice_data;
  logic          slice_valid;
  logic          slice_ready = 1'b1;
  logic          frame_start;
  logic          frame_done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  led_frame_sequencer #(
    .NUM_STRANDS      (NS),
    .LEDS_PER_STRAND  (5),
    .BITS_PER_LED     (24),
    .RESET_GAP_CYCLES (R)
  ) dut (
    .clk_in      (clk_in),
    .ar          (ar),
    .enable      (enable),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_strand   (wr_strand),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .slice_data  (slice_data),
    .slice_valid (slice_valid),
    .slice_ready (slice_ready),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: frame contents, slices left in the current frame, gap cycles left.
  logic [FB-1:0] m_back  [NS];
  logic [FB-1:0] m_front [NS];
  bit m_pending, m_fs, m_fd, m_init;
  int m_left, m_gap;

  function automatic logic [NS-1:0] exp_slice();
    logic [NS-1:0] d;
    for (int s = 0; s < NS; s++) d[s] = m_front[s][m_left-1];
    return d;
  endfunction

  task automatic model_step();
    bit start;
    start = 0;
    if (!ar) begin
      for (int s = 0; s < NS; s++) begin
        m_back[s] = '0;
        m_front[s] = '0;
      end
      m_pending = 0; m_left = 0; m_gap = 0; m_fs = 0; m_fd = 0; m_init = 1;
    end else begin
      m_fs = 0;
      m_fd = 0;
      if (m_left > 0) begin
        if (slice_ready) begin
          m_left--;
          if (m_left == 0) begin
            m_gap = R;
            m_fd = 1;
          end
        end
      end else if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0 && enable) start = 1;
      end else if (enable && m_pending) begin
        start = 1;
      end
      if (wr_valid && !m_pending) begin
        if (int'(wr_strand) < NS) m_back[wr_strand] = wr_data;
        if (wr_last) m_pending = 1;
      end else if (start && m_pending) begin
        for (int s = 0; s < NS; s++) m_front[s] = m_back[s];
        m_pending = 0;
      end
      if (start) begin
        m_left = FB;
        m_fs = 1;
      end
    end
  endtask

  always @(negedge clk_in) begin
    if (m_init) begin
      chk("slice_valid", {127'd0, slice_valid}, {127'd0, m_left > 0});
      chk("busy", {127'd0, busy}, {127'd0, (m_left > 0) || (m_gap > 0)});
      chk("wr_ready", {127'd0, wr_ready}, {127'd0, !m_pending});
      chk("frame_start", {127'd0, frame_start}, {127'd0, m_fs});
      chk("frame_done", {127'd0, frame_done}, {127'd0, m_fd});
      if (m_left > 0) chk("slice_data", {120'd0, slice_data}, {120'd0, exp_slice()});
    end
    model_step();
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr_beat(input logic [2:0] s, input logic [FB-1:0] d, input logic last);
    wr_valid = 1'b1; wr_strand = s; wr_data = d; wr_last = last;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic wait_frame_start(input string nm);
    int n = 0;
    while (!frame_start && n < 3000) begin
      tick();
      n++;
    end
    chk(nm, {127'd0, frame_start}, 128'd1);
  endtask

  localparam logic [FB-1:0] PAT_A = 120'hff000000ff000000ffff0000ffffff;

  initial begin
    logic [FB-1:0] bits;
    logic [FB-1:0] b2;
    logic [NS-1:0] acc;
    int n;

    // Reset state
    ar = 1'b0;
    tick(); tick();
    chk("rst slice_valid", {127'd0, slice_valid}, 128'd0);
    chk("rst slice_data", {120'd0, slice_data}, 128'd0);
    chk("rst busy", {127'd0, busy}, 128'd0);
    chk("rst wr_ready", {127'd0, wr_ready}, 128'd1);
    ar = 1'b1;
    enable = 1'b1;
    slice_ready = 1'b1;

    // First frame: commit latency, length and gap
    wr_beat(3'd0, PAT_A, 1'b0);
    wr_beat(3'd1, PAT_A, 1'b1);
    chk("commit wr_ready", {127'd0, wr_ready}, 128'd0);
    chk("commit+1 slice_valid", {127'd0, slice_valid}, 128'd0);
    tick();
    chk("commit+2 slice_valid", {127'd0, slice_valid}, 128'd1);
    chk("first slice", {120'd0, slice_data}, 128'h03);
    chk("first frame_start", {127'd0, frame_start}, 128'd1);
    n = 0;
    while (slice_valid && n < 1000) begin n++; tick(); end
    chk("frame length", 128'(n), 128'(FB));
    chk("frame_done pulse", {127'd0, frame_done}, 128'd1);
    n = 0;
    while (!slice_valid && n < 1000) begin n++; tick(); end
    chk("gap length", 128'(n), 128'(R));

    // Continuous refresh without new commit
    for (int f = 0; f < 3; f++) begin
      chk("refresh frame_start", {127'd0, frame_start}, 128'd1);
      bits = '0;
      for (int k = 0; k < FB; k++) begin
        bits = {bits[FB-2:0], slice_data[0]};
        tick();
      end
      chk("refresh strand0", {8'd0, bits}, {8'd0, PAT_A});
      n = 0;
      while (!slice_valid && n < 1000) begin n++; tick(); end
    end

    // Random backpressure
    for (int i = 0; i < 600; i++) begin
      slice_ready = 1'($urandom_range(0, 1));
      tick();
    end
    slice_ready = 1'b1;

    // Commit frame B in the middle of a frame
    wait_frame_start("wait frame A");
    repeat (30) tick();
    b2 = {1'b1, 118'd0, 1'b1};
    for (int s = 0; s < NS; s++) begin
      wr_beat(3'(s), (s == 2) ? b2 : ((s == 7) ? {FB{1'b1}} : '0), s == 7);
    end
    chk("midframe wr_ready", {127'd0, wr_ready}, 128'd0);
    wait_frame_start("wait frame B");
    chk("frame B first slice", {120'd0, slice_data}, 128'h84);
    chk("frame B wr_ready", {127'd0, wr_ready}, 128'd1);

    // Disable at bit 60
    repeat (60) tick();
    enable = 1'b0;
    n = 0;
    while (busy && n < 1000) begin n++; tick(); end
    chk("drain cycles", 128'(n), 128'(60 + R));
    chk("drained slice_valid", {127'd0, slice_valid}, 128'd0);
    enable = 1'b1;
    repeat (10) tick();
    chk("idle without commit", {127'd0, busy}, 128'd0);

    // Reset mid-frame
    wr_beat(3'd0, PAT_A, 1'b1);
    wait_frame_start("wait pre-reset frame");
    repeat (40) tick();
    ar = 1'b0;
    tick();
    chk("abort slice_valid", {127'd0, slice_valid}, 128'd0);
    chk("abort busy", {127'd0, busy}, 128'd0);
    chk("abort wr_ready", {127'd0, wr_ready}, 128'd1);
    ar = 1'b1;
    wr_beat(3'd3, '0, 1'b1);
    wait_frame_start("wait zero frame");
    acc = '0;
    for (int k = 0; k < FB; k++) begin
      acc = acc | slice_data;
      tick();
    end
    chk("cleared front", {120'd0, acc}, 128'd0);
    enable = 1'b0;
    n = 0;
    while (busy && n < 1000) begin n++; tick(); end
    chk("final idle", {127'd0, busy}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
Frame scheduler between the upstream pixel source (future HDMI decoder) and the shift-register controller. It holds a double-buffered frame of NUM_STRANDS x FRAME_BITS bits and accepts strand words from upstream on a valid/ready port. It streams one bit per strand per beat, MSB-first, to the shift-register controller on a valid/ready port. After each frame it inserts the LED reset/latch gap, and it swaps in a newly committed frame only at a frame boundary.

Parameters:
NUM_STRANDS, 8, strands driven in parallel (width of slice_data)
LEDS_PER_STRAND, 5, LEDs per strand
BITS_PER_LED, 24, colour bits per LED (G8,R8,B8)
RESET_GAP_CYCLES, 1000, idle cycles between frames (50 us at 20 MHz); must be >= 1

Ports:
clk_in  in  1  system clock
ar  in  1  reset, synchronous, active-low
enable  in  1  1 = keep refreshing; 0 = stop after the current frame and gap
wr_valid  in  1  upstream word valid
wr_ready  out  1  upstream word ready
wr_strand  in  clog2(NUM_STRANDS)  target strand index
wr_data  in  FRAME_BITS  strand word, bit FRAME_BITS-1 is sent first
wr_last  in  1  marks the final word of a frame (commit)
slice_data  out  NUM_STRANDS  bit idx of every front-buffer strand
slice_valid  out  1  slice offered to the shift-register controller
slice_ready  in  1  shift-register controller accepts the slice
frame_start  out  1  one-cycle pulse on entry to SHIFT
frame_done  out  1  one-cycle pulse on entry to GAP
busy  out  1  state != IDLE

Behaviour:
- FRAME_BITS = LEDS_PER_STRAND*BITS_PER_LED (120 by default).
- Storage: front[NUM_STRANDS] and back[NUM_STRANDS], each FRAME_BITS wide; flag pending; bit index idx; gap counter; state.
- Reset (ar=0 at a clk_in edge) sets: both buffers 0, pending=0, idx=FRAME_BITS-1, gap=0, state=IDLE. Outputs after reset: slice_valid=0, slice_data=0, frame_start=0, frame_done=0, busy=0, wr_ready=1.
- A reset asserted mid-frame or mid-gap aborts immediately; no further slices are offered.
- Write port:
  - wr_ready = ~pending.
  - An accepted beat (wr_valid & wr_ready) writes back[wr_strand] <= wr_data.
  - If wr_last is set on that beat, pending <= 1 next cycle.
  - A wr_strand value >= NUM_STRANDS is accepted and discarded. wr_last on such a beat still commits.
  - Strands not written keep their previous back contents.
- Swap: occurs only on the cycle that enters SHIFT, and only if pending=1. It performs front <= back and pending <= 0 in the same edge. A commit seen in that same cycle is impossible, because wr_ready=0 while pending=1.
- FSM states:
  - IDLE: slice_valid=0. If enable & pending, go to SHIFT with swap. If enable & !pending, stay in IDLE; the first frame needs a commit.
  - SHIFT:
    - slice_valid=1 and slice_data[s] = front[s][idx].
    - Outputs are stable while slice_valid & !slice_ready.
    - On an accept with idx>0, idx decrements.
    - On an accept with idx==0, go to GAP: idx <= FRAME_BITS-1, gap <= RESET_GAP_CYCLES-1, frame_done pulses in the first GAP cycle.
  - GAP:
    - slice_valid=0. While gap>0, gap decrements.
    - At gap==0: if enable, go to SHIFT, with swap if pending; otherwise go to IDLE.
    - Without a new commit, the front buffer is re-sent unchanged (continuous refresh).
- frame_start is high in the first SHIFT cycle of every frame.
- Timing:
  - Commit beat at cycle t with state IDLE and enable=1: pending=1 at t+1, slice_valid=1 at t+2.
  - Between the last accepted slice and the next slice_valid there are exactly RESET_GAP_CYCLES cycles with slice_valid=0.
- enable deasserted in SHIFT or GAP: the current frame and its gap complete, then the block enters IDLE. slice_valid never drops mid-frame.
- With slice_ready tied 1, a frame takes FRAME_BITS cycles.

Decomposition:
- Package led_wall_pkg holds:
  - FRAME_BITS derivation function
  - state enum {IDLE, SHIFT, GAP}
  - default LED constants (BITS_PER_LED=24, GRB order)
- One natural sub-module, led_frame_buffer: the double buffer with write port, swap strobe and bit-slice read mux. The FSM and counters stay in the top.

Test Plan:
- Reset, then write strand0=120'hff000000ff000000ffff0000ffffff and strand1=the same with wr_last, slice_ready=1, enable=1 -> slice_valid rises 2 cycles after commit; first slice=8'h03; 120 slices follow; frame_done pulses; then RESET_GAP_CYCLES cycles of slice_valid=0.
- slice_ready toggled randomly on the same frame -> slice_data is held stable while stalled; the accepted bit sequence per strand equals the written words MSB-first.
- Commit frame B mid-way through frame A -> wr_ready=0 until the boundary; frame A finishes unchanged; next frame_start shows B's bits; wr_ready returns to 1.
- No new commit for 3 frames -> the same 120-bit pattern repeats 3 times, each preceded by frame_start.
- enable=0 at bit 60 -> frame completes, gap completes, state IDLE, busy=0; enable=1 with pending=0 -> stays IDLE.
- ar=0 at bit 40 -> next cycle slice_valid=0, busy=0, wr_ready=1, front cleared (a subsequent commit of all-zero strands gives all-zero slices).
